// File: rtl/soft_deser_if.sv
// Bus bundle for soft_deser: serial input and control towards the deserializer, parallel word
// and status back from it.
//   data_i      serial data, one bit per clk
//   calib_i     manual bit-slip request (rising edge)
//   align_en_i  enables automatic word alignment
//   q_o         parallel word (RATIO bits)
//   q_valid_o   one-cycle pulse when q_o updates
//   pclk_o      registered divided clock
//   locked_o    word alignment achieved
//   slip_cnt_o  executed slips modulo RATIO
// The slave modport is the deserializer side, the master modport the driving side.
interface soft_deser_if #(
  parameter int unsigned RATIO = 4
);
  logic             data_i;
  logic             calib_i;
  logic             align_en_i;
  logic [RATIO-1:0] q_o;
  logic             q_valid_o;
  logic             pclk_o;
  logic             locked_o;
  logic [3:0]       slip_cnt_o;

  modport master (
    output data_i, calib_i, align_en_i,
    input  q_o, q_valid_o, pclk_o, locked_o, slip_cnt_o
  );

  modport slave (
    input  data_i, calib_i, align_en_i,
    output q_o, q_valid_o, pclk_o, locked_o, slip_cnt_o
  );
endinterface

// File: rtl/soft_deser.sv
// Soft serial-to-parallel converter with bit-slip and automatic word alignment.
// Ports:
//   clk     fast bit clock, the only clock
//   rst_i   asynchronous active-low reset
//   bus_io  soft_deser_if slave: data_i/calib_i/align_en_i in, q_o/q_valid_o/pclk_o/
//           locked_o/slip_cnt_o out
// A bit counter frames RATIO samples per word. A slip holds the counter at 0 for one extra
// cycle, so that frame is RATIO+1 samples long and the word boundary moves one bit later.
module soft_deser #(
  parameter int unsigned RATIO      = 4,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter logic [9:0]  SYNC_WORD  = 10'h3A5,
  parameter int unsigned LOCK_COUNT = 4
) (
  input logic         clk,
  input logic         rst_i,
  soft_deser_if.slave bus_io
);

  if ((RATIO < 2) || (RATIO > 10)) begin : g_bad_ratio
    $error("soft_deser: RATIO must be in 2..10");
  end
  if ((LOCK_COUNT < 1) || (LOCK_COUNT > 15)) begin : g_bad_lock
    $error("soft_deser: LOCK_COUNT must be in 1..15");
  end

  localparam logic [3:0]       LastCnt  = 4'(RATIO - 1);
  localparam logic [3:0]       HalfCnt  = 4'(RATIO / 2);
  localparam logic [3:0]       LockCnt  = 4'(LOCK_COUNT);
  localparam logic [RATIO-1:0] SyncBits = SYNC_WORD[RATIO-1:0];

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StHunt   = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StVerify = 3'd3;
  localparam logic [2:0] StLocked = 3'd4;

  logic [3:0]       cnt_q, cnt_d;
  logic [RATIO-1:0] sr_q, sr_d;
  logic [RATIO-1:0] q_q, q_d;
  logic             load_q, load_d;
  logic             q_valid_q, q_valid_d;
  logic             pclk_q, pclk_d;
  logic             calib_q, calib_d;
  logic             slip_pend_q, slip_pend_d;
  logic [3:0]       slip_cnt_q, slip_cnt_d;
  logic [2:0]       state_q, state_d;
  logic [3:0]       run_q, run_d;   // match count in VERIFY, mismatch count in LOCKED

  logic slip_exec;
  logic fsm_slip;
  logic slip_req;
  logic word_match;

  // Datapath: framing counter, shift register, word output, divided clock, slip bookkeeping.
  always_comb begin
    slip_exec = slip_pend_q && (cnt_q == 4'd0);

    if (slip_exec || (cnt_q == LastCnt)) begin
      cnt_d = 4'd0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end

    // Oldest sample ends up in bit 0 (LSB_FIRST) or in the MSB, so q_o is a plain copy.
    if (LSB_FIRST) begin
      sr_d = {bus_io.data_i, sr_q[RATIO-1:1]};
    end else begin
      sr_d = {sr_q[RATIO-2:0], bus_io.data_i};
    end

    load_d    = (cnt_q == LastCnt);
    q_valid_d = load_q;
    q_d       = load_q ? sr_q : q_q;
    pclk_d    = (cnt_q < HalfCnt);
    calib_d   = bus_io.calib_i;

    if (slip_exec) begin
      slip_cnt_d = (slip_cnt_q == LastCnt) ? 4'd0 : slip_cnt_q + 4'd1;
    end else begin
      slip_cnt_d = slip_cnt_q;
    end
  end

  // Alignment FSM; word decisions are taken only while q_valid_o is high.
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    fsm_slip   = 1'b0;
    word_match = (q_q == SyncBits);

    if (!bus_io.align_en_i) begin
      state_d = StIdle;
      run_d   = 4'd0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StHunt;
          run_d   = 4'd0;
        end
        StHunt: begin
          if (q_valid_q) begin
            if (word_match) begin
              if (LockCnt == 4'd1) begin
                state_d = StLocked;
                run_d   = 4'd0;
              end else begin
                state_d = StVerify;
                run_d   = 4'd1;
              end
            end else begin
              fsm_slip = 1'b1;
              state_d  = StSettle;
            end
          end
        end
        // The word after a slip request was framed before the slip took effect.
        StSettle: begin
          if (q_valid_q) begin
            state_d = StHunt;
          end
        end
        StVerify: begin
          if (q_valid_q) begin
            if (word_match) begin
              if (run_q + 4'd1 == LockCnt) begin
                state_d = StLocked;
                run_d   = 4'd0;
              end else begin
                run_d = run_q + 4'd1;
              end
            end else begin
              run_d    = 4'd0;
              fsm_slip = 1'b1;
              state_d  = StSettle;
            end
          end
        end
        StLocked: begin
          if (q_valid_q) begin
            if (word_match) begin
              run_d = 4'd0;
            end else if (run_q + 4'd1 == LockCnt) begin
              state_d = StHunt;
              run_d   = 4'd0;
            end else begin
              run_d = run_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = StIdle;
          run_d   = 4'd0;
        end
      endcase
    end

    // Manual requests only count while automatic alignment is off; nothing is queued.
    slip_req = fsm_slip ||
               (!bus_io.align_en_i && bus_io.calib_i && !calib_q);
    if (slip_pend_q) begin
      slip_pend_d = !slip_exec;
    end else begin
      slip_pend_d = slip_req;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q       <= 4'd0;
      sr_q        <= '0;
      q_q         <= '0;
      load_q      <= 1'b0;
      q_valid_q   <= 1'b0;
      pclk_q      <= 1'b0;
      calib_q     <= 1'b0;
      slip_pend_q <= 1'b0;
      slip_cnt_q  <= 4'd0;
      state_q     <= StIdle;
      run_q       <= 4'd0;
    end else begin
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      q_q         <= q_d;
      load_q      <= load_d;
      q_valid_q   <= q_valid_d;
      pclk_q      <= pclk_d;
      calib_q     <= calib_d;
      slip_pend_q <= slip_pend_d;
      slip_cnt_q  <= slip_cnt_d;
      state_q     <= state_d;
      run_q       <= run_d;
    end
  end

  assign bus_io.q_o        = q_q;
  assign bus_io.q_valid_o  = q_valid_q;
  assign bus_io.pclk_o     = pclk_q;
  assign bus_io.locked_o   = (state_q == StLocked);
  assign bus_io.slip_cnt_o = slip_cnt_q;

endmodule

// File: tb/tb_soft_deser.sv
// Bench for soft_deser: instance A (RATIO 4, LSB first, sync 4'h5) is checked every cycle
// against a frame-level reference model; instance B (RATIO 10, MSB first, sync 10'h3A5) is
// driven from a table of words with expected outputs.
module tb_soft_deser;

  localparam int unsigned AR    = 4;
  localparam logic [3:0]  ASync = 4'h5;
  localparam int          ALock = 4;
  localparam int unsigned BR    = 10;

  localparam int MIdle   = 0;
  localparam int MHunt   = 1;
  localparam int MSettle = 2;
  localparam int MVerify = 3;
  localparam int MLocked = 4;

  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  soft_deser_if #(.RATIO(AR)) a_if ();
  soft_deser_if #(.RATIO(BR)) b_if ();

  soft_deser #(
    .RATIO(AR), .LSB_FIRST(1'b1), .SYNC_WORD(10'h005), .LOCK_COUNT(ALock)
  ) u_a (
    .clk(clk), .rst_i(rst_i), .bus_io(a_if)
  );

  soft_deser #(
    .RATIO(BR), .LSB_FIRST(1'b0), .SYNC_WORD(10'h3A5), .LOCK_COUNT(4)
  ) u_b (
    .clk(clk), .rst_i(rst_i), .bus_io(b_if)
  );

  int n_cmp;
  int n_fail;
  int ecnt;  // edges since last reset release

  // ---------------- reference model for instance A ----------------
  int         m_pos;         // samples taken so far in the current frame
  bit         m_slip_frame;  // current frame is RATIO+1 long
  bit         m_pend;
  bit         m_calib_prev;
  bit         m_done;
  logic [3:0] m_word;
  bit         fr[$];
  int         m_mode;
  int         m_run;
  logic [3:0] e_q;
  bit         e_valid;
  bit         e_pclk;
  int         e_slips;

  always @(posedge clk or negedge rst_i) begin
    bit req, exec, pend_old;
    int cnt_eq;
    if (!rst_i) begin
      m_pos = 0; m_slip_frame = 0; m_pend = 0; m_calib_prev = 0; m_done = 0;
      m_word = '0; fr.delete(); m_mode = MIdle; m_run = 0;
      e_q = '0; e_valid = 0; e_pclk = 0; e_slips = 0;
    end else begin
      req = 0;
      exec = 0;
      if (!a_if.align_en_i) begin
        m_mode = MIdle;
        m_run  = 0;
      end else begin
        case (m_mode)
          MIdle: m_mode = MHunt;
          MHunt: if (e_valid) begin
            if (e_q == ASync) begin m_mode = MVerify; m_run = 1; end
            else begin req = 1; m_mode = MSettle; end
          end
          MSettle: if (e_valid) m_mode = MHunt;
          MVerify: if (e_valid) begin
            if (e_q == ASync) begin
              m_run++;
              if (m_run == ALock) begin m_mode = MLocked; m_run = 0; end
            end else begin
              m_run = 0; req = 1; m_mode = MSettle;
            end
          end
          default: if (e_valid) begin
            if (e_q == ASync) m_run = 0;
            else begin
              m_run++;
              if (m_run == ALock) begin m_mode = MHunt; m_run = 0; end
            end
          end
        endcase
      end
      if (!a_if.align_en_i && a_if.calib_i && !m_calib_prev) req = 1;
      m_calib_prev = a_if.calib_i;

      pend_old = m_pend;
      if (m_pos == 0) begin
        m_slip_frame = pend_old;
        if (pend_old) begin
          exec = 1;
          e_slips = (e_slips + 1) % AR;
        end
      end
      m_pend = pend_old ? !exec : req;

      // In a slipped frame the first position is counted twice.
      cnt_eq = (m_slip_frame && m_pos > 0) ? m_pos - 1 : m_pos;
      e_pclk = (cnt_eq < AR / 2);

      e_valid = m_done;
      if (m_done) e_q = m_word;
      m_done = 0;

      fr.push_back(a_if.data_i);
      m_pos++;
      if (m_pos == AR + (m_slip_frame ? 1 : 0)) begin
        for (int i = 0; i < AR; i++) m_word[i] = fr[fr.size() - AR + i];
        m_done = 1;
        m_pos  = 0;
        fr.delete();
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_a();
    cmp("a_q_o", 32'(a_if.q_o), 32'(e_q));
    cmp("a_q_valid_o", 32'(a_if.q_valid_o), 32'(e_valid));
    cmp("a_pclk_o", 32'(a_if.pclk_o), 32'(e_pclk));
    cmp("a_locked_o", 32'(a_if.locked_o), 32'(m_mode == MLocked));
    cmp("a_slip_cnt_o", 32'(a_if.slip_cnt_o), 32'(e_slips));
  endtask

  task automatic step();
    @(negedge clk);
    ecnt++;
    check_a();
  endtask

  task automatic wait_lock(input string name, input int budget);
    int n = 0;
    while (a_if.locked_o !== 1'b1 && n < budget) begin
      a_if.data_i = (ecnt % 2 == 1);
      step();
      n++;
    end
    cmp(name, 32'(a_if.locked_o), 32'd1);
  endtask

  // Waits for a frame boundary, then sends nbad all-zero words and ngood sync words.
  task automatic send_frames(input int nbad, input int ngood);
    int guard = 0;
    while (m_pos != 0 && guard < 20) begin
      a_if.data_i = (ecnt % 2 == 1);
      step();
      guard++;
    end
    for (int i = 0; i < 4 * nbad; i++) begin
      a_if.data_i = 1'b0;
      step();
    end
    for (int i = 0; i < 4 * ngood; i++) begin
      a_if.data_i = (ecnt % 2 == 1);
      step();
    end
  endtask

  typedef struct {
    logic [9:0] tx;
    logic [9:0] exp_q;
    bit         exp_locked;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int  wi;
    bit  syncmode;
    logic [9:0] w;

    tbl[0]  = '{10'h3A5, 10'h3A5, 1'b0};
    tbl[1]  = '{10'h3A5, 10'h3A5, 1'b0};
    tbl[2]  = '{10'h3A5, 10'h3A5, 1'b0};
    tbl[3]  = '{10'h3A5, 10'h3A5, 1'b1};
    tbl[4]  = '{10'h000, 10'h000, 1'b1};
    tbl[5]  = '{10'h3FF, 10'h3FF, 1'b1};
    tbl[6]  = '{10'h155, 10'h155, 1'b1};
    tbl[7]  = '{10'h3A5, 10'h3A5, 1'b1};
    tbl[8]  = '{10'h2AA, 10'h2AA, 1'b1};
    tbl[9]  = '{10'h2AA, 10'h2AA, 1'b1};
    tbl[10] = '{10'h2AA, 10'h2AA, 1'b1};
    tbl[11] = '{10'h0F0, 10'h0F0, 1'b0};

    n_cmp = 0;
    n_fail = 0;
    ecnt = 0;
    a_if.data_i = 1'b0; a_if.calib_i = 1'b0; a_if.align_en_i = 1'b0;
    b_if.data_i = 1'b0; b_if.calib_i = 1'b0; b_if.align_en_i = 1'b0;

    // Reset state
    #3 rst_i = 1'b0;
    repeat (3) step();
    cmp("rst_a_q_o", 32'(a_if.q_o), 32'd0);
    cmp("rst_a_q_valid_o", 32'(a_if.q_valid_o), 32'd0);
    cmp("rst_a_pclk_o", 32'(a_if.pclk_o), 32'd0);
    cmp("rst_a_locked_o", 32'(a_if.locked_o), 32'd0);
    cmp("rst_a_slip_cnt_o", 32'(a_if.slip_cnt_o), 32'd0);
    cmp("rst_b_q_o", 32'(b_if.q_o), 32'd0);
    cmp("rst_b_locked_o", 32'(b_if.locked_o), 32'd0);

    // Phase 1: A gets 1,0,0,0 with two calib edges; B runs the word table with alignment on.
    rst_i = 1'b1;
    ecnt = 0;
    b_if.align_en_i = 1'b1;
    for (int e = 0; e < 126; e++) begin
      a_if.data_i  = (e % 4 == 0);
      a_if.calib_i = (e == 41 || e == 43);
      wi = e / 10;
      if (wi < 12) begin
        w = tbl[wi].tx;
        b_if.data_i = w[9 - (e % 10)];
      end else begin
        b_if.data_i = 1'b0;
      end
      step();
      cmp("b_pclk_o", 32'(b_if.pclk_o), 32'((e % 10) < 5));
      if (e >= 10 && e % 10 == 0 && e / 10 - 1 < 12) begin
        cmp("b_q_valid_o", 32'(b_if.q_valid_o), 32'd1);
        cmp("b_q_o", 32'(b_if.q_o), 32'(tbl[e / 10 - 1].exp_q));
      end
      if (e >= 11 && e % 10 == 1 && (e - 11) / 10 < 12) begin
        cmp("b_locked_o", 32'(b_if.locked_o), 32'(tbl[(e - 11) / 10].exp_locked));
      end
      if (e == 30) cmp("a_word_before_slip", 32'(a_if.q_o), 32'h1);
      if (e == 70) begin
        cmp("a_word_after_slip", 32'(a_if.q_o), 32'h8);
        cmp("a_slip_count", 32'(a_if.slip_cnt_o), 32'd1);
      end
    end
    b_if.align_en_i = 1'b0;
    a_if.calib_i = 1'b0;

    // Phase 2: alignment on a 4'h5 stream offset by one bit, then lock-loss behaviour.
    rst_i = 1'b0;
    repeat (2) step();
    rst_i = 1'b1;
    ecnt = 0;
    a_if.align_en_i = 1'b1;
    wait_lock("lock_acquired", 400);
    send_frames(3, 1);
    repeat (2) begin a_if.data_i = (ecnt % 2 == 1); step(); end
    cmp("locked_after_3_bad", 32'(a_if.locked_o), 32'd1);
    send_frames(4, 0);
    repeat (2) begin a_if.data_i = (ecnt % 2 == 1); step(); end
    cmp("unlock_after_4_bad", 32'(a_if.locked_o), 32'd0);

    // Phase 3: relock, then asynchronous reset in the middle of a frame.
    wait_lock("relock", 400);
    repeat (2) begin a_if.data_i = (ecnt % 2 == 1); step(); end
    @(posedge clk);
    #2 rst_i = 1'b0;
    #1;
    cmp("async_rst_q_o", 32'(a_if.q_o), 32'd0);
    cmp("async_rst_q_valid_o", 32'(a_if.q_valid_o), 32'd0);
    cmp("async_rst_pclk_o", 32'(a_if.pclk_o), 32'd0);
    cmp("async_rst_locked_o", 32'(a_if.locked_o), 32'd0);
    cmp("async_rst_slip_cnt_o", 32'(a_if.slip_cnt_o), 32'd0);
    repeat (2) step();
    rst_i = 1'b1;
    ecnt = 0;
    repeat (15) begin a_if.data_i = (ecnt % 2 == 1); step(); end
    cmp("no_early_relock", 32'(a_if.locked_o), 32'd0);
    wait_lock("relock_after_reset", 400);

    // Phase 4: randomized stimulus against the model.
    syncmode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) syncmode = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 199) == 0) a_if.align_en_i = ~a_if.align_en_i;
      if ($urandom_range(0, 7) == 0) a_if.calib_i = ~a_if.calib_i;
      if (syncmode) begin
        a_if.data_i = (ecnt % 2 == 1) ^ ($urandom_range(0, 31) == 0);
      end else begin
        a_if.data_i = ($urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 599) == 0) begin
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        ecnt = 0;
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/soft_deser.md
SOFT_DESER -- requirements
Module: soft_deser

Interface
REQ-001 SHALL have parameter RATIO, default 4: deserialization factor, legal 2..10; others rejected at elaboration.
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 puts the first-received bit of a word in q_o[0]; 0 puts it in q_o[RATIO-1].
REQ-003 SHALL have parameter SYNC_WORD, default 10'h3A5: alignment pattern; only bits [RATIO-1:0] are compared.
REQ-004 SHALL have parameter LOCK_COUNT, default 4: consecutive matches to lock, and consecutive mismatches to lose lock; legal 1..15.
REQ-005 SHALL have port clk, input, 1: fast bit clock; the only clock; every flop on its rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port data_i, input, 1: serial data, one bit sampled per clk.
REQ-008 SHALL have port calib_i, input, 1: manual bit-slip request, acted on at its rising edge.
REQ-009 SHALL have port align_en_i, input, 1: 1 enables automatic word alignment.
REQ-010 SHALL have port q_o, output, RATIO: parallel word.
REQ-011 SHALL have port q_valid_o, output, 1: one-cycle pulse when q_o updates.
REQ-012 SHALL have port pclk_o, output, 1: registered divided clock, period RATIO cycles (RATIO+1 on a slipped frame).
REQ-013 SHALL have port locked_o, output, 1: alignment achieved.
REQ-014 SHALL have port slip_cnt_o, output, 4: executed slips modulo RATIO.

Function
REQ-015 SHALL sample data_i every cycle into a RATIO-bit shift register and keep a bit counter cnt cycling 0..RATIO-1.
REQ-016 SHALL load q_o with the last RATIO samples, bit order per LSB_FIRST, on the edge after the cnt==RATIO-1 sample, and pulse q_valid_o high for exactly that cycle.
REQ-017 SHALL hold q_o stable between q_valid_o pulses.
REQ-018 SHALL drive pclk_o high while cnt < floor(RATIO/2), else low, registered; for RATIO=3, high 1 cycle and low 2.
REQ-019 SHALL detect a calib_i rising edge with a registered copy of calib_i, and set a single slip-pending flag.
REQ-020 SHALL execute a pending slip when cnt==0 by holding cnt at 0 one extra cycle; the frame spans RATIO+1 samples, the oldest is discarded, and the word boundary moves one bit later.
REQ-021 SHALL ignore slip requests arriving while a slip is pending; requests are not queued.
REQ-022 SHALL increment slip_cnt_o on each executed slip, wrapping from RATIO-1 to 0.
REQ-023 SHALL ignore calib_i while align_en_i=1; the alignment FSM is then the only slip source.
REQ-024 SHALL implement alignment FSM states IDLE, HUNT, SETTLE, VERIFY, LOCKED, evaluated only on q_valid_o cycles unless stated otherwise.
REQ-025 IDLE: align_en_i=1 -> HUNT on the next cycle.
REQ-026 HUNT: word==SYNC -> VERIFY with match count 1 (LOCKED directly if LOCK_COUNT=1); mismatch -> request slip, go to SETTLE.
REQ-027 SETTLE: discard the next word without comparing it, then -> HUNT.
REQ-028 VERIFY: match -> increment match count, LOCKED at LOCK_COUNT; mismatch -> clear count, request slip, go to SETTLE.
REQ-029 LOCKED: locked_o=1; count consecutive mismatches, with any match clearing the count; LOCK_COUNT consecutive mismatches -> HUNT and locked_o=0 the same cycle.
REQ-030 align_en_i=0 in any state -> IDLE on the next edge, clearing counts and locked_o; a slip already pending still executes.

Reset
REQ-031 SHALL asynchronously force, on rst_i low, q_o=0, q_valid_o=0, pclk_o=0, locked_o=0, slip_cnt_o=0, cnt=0, shift register=0, slip pending=0, calib copy=0, FSM=IDLE.
REQ-032 SHALL release reset synchronously; the first sample is taken on the first clk edge with rst_i high; a reset mid-frame or mid-slip discards all partial state.

Verification
REQ-033 RATIO=4, LSB_FIRST=1, data 1,0,0,0 repeating from reset release -> q_o=4'h1 with a q_valid_o pulse every 4 cycles; pclk_o 2 high, 2 low.
REQ-034 RATIO=4, same stream, one calib_i pulse -> one 5-cycle frame, then q_o=4'h8; slip_cnt_o=1; a second calib_i edge while pending has no effect.
REQ-035 RATIO=4, align_en_i=1, repeating 4'h5 stream offset by 1 bit -> HUNT/SETTLE/slip cycles until match; locked_o=1 after 4 consecutive 4'h5 words.
REQ-036 Locked, inject 3 bad words then a good one -> locked_o stays 1; inject 4 bad words -> locked_o=0, FSM in HUNT.
REQ-037 rst_i low mid-frame while locked -> all outputs 0 immediately; after release, locked_o reasserts only after a fresh match sequence.
REQ-038 RATIO=10, LSB_FIRST=0, SYNC_WORD=10'h3A5 stream aligned -> q_o=10'h3A5 every 10 cycles; pclk_o 5 high, 5 low; locked_o=1 after 4 words.
